// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MC    = 2'd1,
        FLUSH = 2'd2
    } pctrl_state_t;

    // Bit positions inside the stall vector, oldest stage last.
    localparam int unsigned STALL_PC  = 0;
    localparam int unsigned STALL_IF  = 1;
    localparam int unsigned STALL_ID  = 2;
    localparam int unsigned STALL_EX  = 3;
    localparam int unsigned STALL_MEM = 4;
    localparam int unsigned STALL_WB  = 5;

    typedef logic [STALL_WB:0] stall_vec_t;

    // Hold patterns: everything up to and including the stage that needs the hold.
    localparam stall_vec_t STALL_NONE_V = 6'b000000;
    localparam stall_vec_t STALL_ID_V   = 6'b000111;
    localparam stall_vec_t STALL_EX_V   = 6'b001111;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/control bundle between the datapath (master) and the sequencer (slave).
import pipe_ctrl_pkg::*;

interface pipe_ctrl_if #(
    parameter int unsigned CNT_W = 5
);
    logic             stallreq_id;
    logic             stallreq_ex;
    logic             mc_start;
    logic [CNT_W-1:0] mc_cycles;
    logic             flush_req;
    stall_vec_t       stall;
    logic             flush;
    logic             mc_busy;
    logic             mc_done;

    modport master (
        output stallreq_id, stallreq_ex, mc_start, mc_cycles, flush_req,
        input  stall, flush, mc_busy, mc_done
    );

    modport slave (
        input  stallreq_id, stallreq_ex, mc_start, mc_cycles, flush_req,
        output stall, flush, mc_busy, mc_done
    );
endinterface

// File: rtl/pipe_ctrl_mc_counter.sv
// Loadable down-counter tracking the remaining EX occupancy of a multi-cycle op.
module mc_counter #(
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    input  logic             clear,
    output logic             is_last
);
    logic [CNT_W-1:0] cnt;

    // Clear beats load beats decrement; the count saturates at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign is_last = (cnt == CNT_W'(1));
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stall requests, holds EX for multi-cycle ops, sequences flushes.
import pipe_ctrl_pkg::*;

module pipe_ctrl #(
    parameter int unsigned CNT_W        = 5,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input logic       clk,
    input logic       rst,
    pipe_ctrl_if.slave bus
);
    localparam int unsigned FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FW-1:0] FLUSH_RELOAD = FW'(FLUSH_CYCLES - 1);

    pctrl_state_t     state;
    pctrl_state_t     state_nxt;
    logic [FW-1:0]    flush_cnt;
    logic [FW-1:0]    flush_cnt_nxt;

    logic [CNT_W-1:0] mc_len;
    logic             mc_long;
    logic             mc_short;
    logic             mc_load;
    logic             mc_dec;
    logic             mc_last;

    stall_vec_t       stall_o;
    logic             flush_o;
    logic             busy_o;
    logic             done_o;

    assign mc_len   = bus.mc_cycles;
    assign mc_long  = bus.mc_start && (mc_len > CNT_W'(1));
    assign mc_short = bus.mc_start && (mc_len <= CNT_W'(1));

    // A flush in the same cycle suppresses the load, so the aborted op leaves cnt at zero.
    assign mc_load  = (state == IDLE) && mc_long && !bus.flush_req;
    assign mc_dec   = (state == MC) && !bus.flush_req;

    mc_counter #(
        .CNT_W(CNT_W)
    ) u_mc_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (mc_load),
        .load_val (mc_len - CNT_W'(1)),
        .dec      (mc_dec),
        .clear    (bus.flush_req),
        .is_last  (mc_last)
    );

    // State and flush-length registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    // Next-state logic; a flush request overrides every other transition.
    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        if (bus.flush_req) begin
            flush_cnt_nxt = FLUSH_RELOAD;
            if (FLUSH_CYCLES > 1) begin
                state_nxt = FLUSH;
            end else begin
                state_nxt = IDLE;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (mc_long) begin
                        state_nxt = MC;
                    end
                end
                MC: begin
                    if (mc_last) begin
                        state_nxt = IDLE;
                    end
                end
                FLUSH: begin
                    if (flush_cnt != '0) begin
                        flush_cnt_nxt = flush_cnt - FW'(1);
                    end
                    if (flush_cnt <= FW'(1)) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output decode: flush first, then EX hold, then ID hold.
    always_comb begin
        stall_o = STALL_NONE_V;
        flush_o = 1'b0;
        busy_o  = (state == MC);
        done_o  = 1'b0;
        if ((state == FLUSH) || bus.flush_req) begin
            flush_o = 1'b1;
        end else begin
            if (state == IDLE) begin
                done_o = mc_short;
            end else if (state == MC) begin
                done_o = mc_last;
            end
            if (((state == MC) && !mc_last) || ((state == IDLE) && mc_long) || bus.stallreq_ex) begin
                stall_o = STALL_EX_V;
            end else if (bus.stallreq_id) begin
                stall_o = STALL_ID_V;
            end
        end
    end

    assign bus.stall   = stall_o;
    assign bus.flush   = flush_o;
    assign bus.mc_busy = busy_o;
    assign bus.mc_done = done_o;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed per-cycle vectors, checked on the falling edge.
module tb_pipe_ctrl;
    localparam logic [5:0] N = 6'b000000;
    localparam logic [5:0] I = 6'b000111;
    localparam logic [5:0] E = 6'b001111;

    typedef struct {
        logic [5:0] stall;
        logic       flush;
        logic       busy;
        logic       done;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pipe_ctrl_if #(.CNT_W(5)) bus ();

    pipe_ctrl #(
        .CNT_W        (5),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t  exp_q[$];
    string name_q[$];
    int    compared   = 0;
    int    mismatched = 0;

    // Monitor: one expected record per cycle, compared away from the rising edge.
    initial begin
        exp_t  e;
        string n;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                compared++;
                if ({bus.stall, bus.flush, bus.mc_busy, bus.mc_done} !== {e.stall, e.flush, e.busy, e.done}) begin
                    mismatched++;
                    $display("FAIL %s: got stall=%b flush=%b busy=%b done=%b, want stall=%b flush=%b busy=%b done=%b",
                             n, bus.stall, bus.flush, bus.mc_busy, bus.mc_done,
                             e.stall, e.flush, e.busy, e.done);
                end
            end
        end
    end

    task automatic cyc(input logic r, input logic sid, input logic sex, input logic mcs,
                       input logic [4:0] mcc, input logic fr,
                       input logic [5:0] es, input logic ef, input logic eb, input logic ed,
                       input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst             = r;
        bus.stallreq_id = sid;
        bus.stallreq_ex = sex;
        bus.mc_start    = mcs;
        bus.mc_cycles   = mcc;
        bus.flush_req   = fr;
        e.stall = es;
        e.flush = ef;
        e.busy  = eb;
        e.done  = ed;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.stallreq_id = 1'b0;
        bus.stallreq_ex = 1'b0;
        bus.mc_start    = 1'b0;
        bus.mc_cycles   = '0;
        bus.flush_req   = 1'b0;

        // reset
        cyc(1, 0,0,0,5'd0,0, N,0,0,0, "rst_hold");
        cyc(0, 0,0,0,5'd0,0, N,0,0,0, "idle_after_rst");
        // 4-cycle op
        cyc(0, 0,0,1,5'd4,0, E,0,0,0, "mc4_start");
        cyc(0, 0,0,0,5'd0,0, E,0,1,0, "mc4_c2");
        cyc(0, 0,0,0,5'd0,0, E,0,1,0, "mc4_c3");
        cyc(0, 0,0,0,5'd0,0, N,0,1,1, "mc4_last");
        cyc(0, 0,0,0,5'd0,0, N,0,0,0, "mc4_idle");
        // single-cycle ops and shortest multi-cycle op
        cyc(0, 0,0,1,5'd1,0, N,0,0,1, "mc1_done");
        cyc(0, 0,0,0,5'd0,0, N,0,0,0, "mc1_after");
        cyc(0, 0,0,1,5'd0,0, N,0,0,1, "mc0_done");
        cyc(0, 0,0,1,5'd2,0, E,0,0,0, "mc2_start");
        cyc(0, 0,0,0,5'd0,0, N,0,1,1, "mc2_last");
        cyc(0, 0,0,0,5'd0,0, N,0,0,0, "mc2_idle");
        // stall merging
        cyc(0, 1,0,0,5'd0,0, I,0,0,0, "sid_only");
        cyc(0, 1,1,0,5'd0,0, E,0,0,0, "sid_sex");
        cyc(0, 0,1,0,5'd0,0, E,0,0,0, "sex_only");
        cyc(0, 0,0,0,5'd0,0, N,0,0,0, "stall_release");
        // mc_start ignored while busy; ID hold surfaces on the last cycle
        cyc(0, 0,0,1,5'd3,0, E,0,0,0, "mc3_start");
        cyc(0, 1,0,1,5'd7,0, E,0,1,0, "mc3_restart_ignored");
        cyc(0, 1,0,0,5'd0,0, I,0,1,1, "mc3_last_sid");
        cyc(0, 0,0,0,5'd0,0, N,0,0,0, "mc3_idle");
        // flush on 2nd cycle of a 5-cycle op
        cyc(0, 0,0,1,5'd5,0, E,0,0,0, "mc5_start");
        cyc(0, 0,1,0,5'd0,1, N,1,1,0, "mc5_flush");
        cyc(0, 1,0,0,5'd0,0, N,1,0,0, "flush_hold");
        cyc(0, 0,0,0,5'd0,0, N,0,0,0, "flush_end");
        cyc(0, 0,0,0,5'd0,0, N,0,0,0, "no_late_done");
        // flush extension
        cyc(0, 0,0,0,5'd0,1, N,1,0,0, "fx_req");
        cyc(0, 0,0,0,5'd0,1, N,1,0,0, "fx_reload");
        cyc(0, 0,0,0,5'd0,0, N,1,0,0, "fx_tail");
        cyc(0, 0,0,0,5'd0,0, N,0,0,0, "fx_end");
        // flush and mc_start together
        cyc(0, 1,1,1,5'd4,1, N,1,0,0, "fr_mcs");
        cyc(0, 0,0,0,5'd0,0, N,1,0,0, "fr_mcs_flush");
        cyc(0, 0,0,0,5'd0,0, N,0,0,0, "fr_mcs_idle");
        cyc(0, 0,0,0,5'd0,0, N,0,0,0, "fr_mcs_nobusy");
        cyc(0, 0,0,1,5'd1,1, N,1,0,0, "fr_mc1_nodone");
        cyc(0, 0,0,0,5'd0,0, N,1,0,0, "fr_mc1_flush");
        cyc(0, 0,0,0,5'd0,0, N,0,0,0, "fr_mc1_idle");
        // reset mid-op (cnt=3 when rst rises)
        cyc(0, 0,0,1,5'd5,0, E,0,0,0, "rmc_start");
        cyc(0, 0,0,0,5'd0,0, E,0,1,0, "rmc_c2");
        cyc(1, 0,0,0,5'd0,0, N,0,0,0, "rmc_rst");
        cyc(0, 1,0,0,5'd0,0, I,0,0,0, "rmc_idle_sid");
        cyc(0, 0,0,0,5'd0,0, N,0,0,0, "rmc_idle");

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d expected records left unchecked, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
